// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
//   Shared definitions for the instruction-memory boot loader and the core
//   memory models that sit behind it.
//
//   - Default memory geometry (words per memory and the matching word-address
//     width) so the loader and the memory models agree on one value.
//   - Default reset-hold length and the width of the hold counter.
//   - The 3-bit boot sequencer state encoding.
// ---------------------------------------------------------------------------
package boot_pkg;

    // Default geometry of insn_memory / data_memory (words).
    localparam int BOOT_DEPTH    = 1024;
    // Word-address width; must equal $clog2(BOOT_DEPTH).
    localparam int BOOT_ADDR_W   = 10;
    // Cycles the core reset stays asserted after the final program write.
    localparam int BOOT_RST_HOLD = 4;
    // Hold counter width: enough for the full 1..15 hold range.
    localparam int HOLD_W        = 4;

    // Boot sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERROR   = 3'd5
    } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_hold_counter.sv
// ---------------------------------------------------------------------------
// hold_counter
//   Loadable down-counter with a zero flag. The boot loader loads it with the
//   reset-hold length on the last program write and counts it down while
//   waiting to release the core.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset (count -> 0)
//   load       in   load load_value this cycle (has priority over dec)
//   load_value in   W  value to load
//   dec        in   decrement by one; saturates at zero
//   zero       out  count is zero
// ---------------------------------------------------------------------------
module hold_counter
    import boot_pkg::*;
#(
    parameter int W = HOLD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time sequencer for the single-cycle RV32I core. After a start pulse
//   it holds the core in reset, zero-fills instruction and data memory, then
//   streams a program into instruction memory over a valid/ready word
//   interface and finally releases the core.
//
//   Handshake: a word on s_data is accepted on a rising clock edge where
//   s_valid and s_ready are both 1. s_ready is a registered output, asserted
//   only in LOAD; s_valid must stay asserted with stable s_data/s_last until
//   the word is accepted.
//
//   Every memory-side output is registered: a write decided on one edge is
//   presented on imem_* / dmem_* for the following cycle.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle pulse; begins a clear+load sequence
//   s_valid      in   program word valid
//   s_ready      out  loader accepts a word this cycle
//   s_data       in   32  instruction word
//   s_last       in   marks the final program word
//   imem_we      out  instruction memory write enable
//   imem_addr    out  ADDR_W  instruction memory word address
//   imem_wdata   out  32  instruction memory write data
//   dmem_we      out  data memory write enable (write data is always 0)
//   dmem_addr    out  ADDR_W  data memory word address
//   core_rst_n   out  active-low reset driven to the core
//   done         out  program loaded, core running
//   error        out  program overflowed DEPTH
//   loaded_words out  ADDR_W+1  words accepted in the last load
//   fsm_state    out  3  current sequencer state (boot_state_e encoding)
// ---------------------------------------------------------------------------
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH    = BOOT_DEPTH,
    parameter int ADDR_W   = BOOT_ADDR_W,
    parameter int RST_HOLD = BOOT_RST_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_words,
    output logic [2:0]        fsm_state
);

    // Legacy-compatible state constants taken from the shared encoding.
    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] CLEAR   = ST_CLEAR;
    localparam logic [2:0] LOAD    = ST_LOAD;
    localparam logic [2:0] RELEASE = ST_RELEASE;
    localparam logic [2:0] RUN     = ST_RUN;
    localparam logic [2:0] ERROR   = ST_ERROR;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Geometry sanity: the address counter wraps exactly at DEPTH only when
    // the address width matches, and the hold counter has 4 bits.
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("imem_boot_loader: ADDR_W must equal clog2(DEPTH)");
    end
    if ((RST_HOLD < 1) || (RST_HOLD > 15)) begin : g_bad_rst_hold
        $error("imem_boot_loader: RST_HOLD must be within 1..15");
    end

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_at_top;
    logic              beat;
    logic              hold_load;
    logic              hold_zero;

    assign cnt_at_top = (cnt == LAST_ADDR);
    assign beat       = (state == LOAD) && s_valid && s_ready;
    // Arm the hold counter on the edge that schedules the final write, so
    // its count-down starts with the cycle in which that write is visible.
    assign hold_load  = beat && s_last;
    assign fsm_state  = state;

    hold_counter #(
        .W (HOLD_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .load_value (HOLD_W'(RST_HOLD)),
        .dec        (state == RELEASE),
        .zero       (hold_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            s_ready      <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            loaded_words <= '0;
        end else begin
            // Write strobes are single-cycle unless re-asserted below.
            imem_we <= 1'b0;
            dmem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= CLEAR;
                        cnt          <= '0;
                        loaded_words <= '0;
                    end
                end

                CLEAR: begin
                    imem_we    <= 1'b1;
                    dmem_we    <= 1'b1;
                    imem_addr  <= cnt;
                    dmem_addr  <= cnt;
                    imem_wdata <= '0;
                    if (cnt_at_top) begin
                        state   <= LOAD;
                        cnt     <= '0;
                        s_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end

                LOAD: begin
                    if (beat) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= cnt;
                        imem_wdata   <= s_data;
                        cnt          <= cnt + ADDR_W'(1);
                        loaded_words <= loaded_words + (ADDR_W + 1)'(1);
                        // s_last wins over overflow: a program that exactly
                        // fills the memory is a valid program.
                        if (s_last) begin
                            state   <= RELEASE;
                            s_ready <= 1'b0;
                        end else if (cnt_at_top) begin
                            state   <= ERROR;
                            s_ready <= 1'b0;
                            error   <= 1'b1;
                        end
                    end
                end

                RELEASE: begin
                    if (hold_zero) begin
                        state      <= RUN;
                        core_rst_n <= 1'b1;
                        done       <= 1'b1;
                    end
                end

                RUN: begin
                    if (start) begin
                        state        <= CLEAR;
                        cnt          <= '0;
                        loaded_words <= '0;
                        core_rst_n   <= 1'b0;
                        done         <= 1'b0;
                    end
                end

                ERROR: begin
                    if (start) begin
                        state        <= CLEAR;
                        cnt          <= '0;
                        loaded_words <= '0;
                        error        <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Self-checking bench for imem_boot_loader (small DEPTH so the overflow
//   path is reachable). Expected memory writes are kept in order in exp_q;
//   a negedge monitor compares every observed write against the queue and
//   measures the distance from the last write to the core reset release.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int RST_HOLD = 4;
    localparam int REC_W    = 1 + ADDR_W + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              s_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic              core_rst_n;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   loaded_words;
    logic [2:0]        fsm_state;

    imem_boot_loader #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error),
        .loaded_words (loaded_words),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [REC_W-1:0] exp_q[$];   // {dmem_also, addr, data}
    logic [31:0] words[DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int   cyc         = 0;
    int   last_wr_cyc = 0;
    logic prev_core   = 1'b0;

    always @(negedge clk) begin : monitor
        logic [REC_W-1:0] rec;
        cyc++;
        if (reset) begin
            if (imem_we || dmem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {dmem_we, imem_we}, 2'b00);
                end else begin
                    rec = exp_q.pop_front();
                    check("wr_rec", {dmem_we, imem_we, imem_addr, imem_wdata},
                          {rec[REC_W-1], 1'b1, rec[32 +: ADDR_W], rec[31:0]});
                    if (dmem_we) check("dmem_addr", dmem_addr, rec[32 +: ADDR_W]);
                    check("core_held_during_write", core_rst_n, 1'b0);
                end
                last_wr_cyc = cyc;
            end
            if (core_rst_n && !prev_core) begin
                check("hold_latency", cyc - last_wr_cyc, RST_HOLD + 1);
                check("done_at_release", done, 1'b1);
            end
            prev_core = core_rst_n;
        end else begin
            prev_core = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Pulse start for one cycle; when a clear is expected, queue DEPTH zero
    // writes to both memories first.
    task automatic pulse_start(input bit expect_clear);
        if (expect_clear) begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b1, ADDR_W'(i), 32'h0});
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (expect_clear) begin
            check("start_core_rst_n", core_rst_n, 1'b0);
            check("start_done", done, 1'b0);
            check("start_error", error, 1'b0);
        end
    endtask

    // Offer words[0..n-1] with random gaps in s_valid. The last word carries
    // s_last when with_last is set.
    task automatic send_words(input int n, input bit with_last, input bit expect_drop);
        int sent   = 0;
        int budget = 0;
        while (sent < n && budget < 4000) begin
            @(negedge clk);
            budget++;
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = words[sent];
            s_last  = with_last && (sent == n - 1);
            if (s_valid && s_ready) begin
                exp_q.push_back({1'b0, ADDR_W'(sent), words[sent]});
                sent++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
        check("send_count", sent, n);
        if (expect_drop) check("s_ready_drop", s_ready, 1'b0);
    endtask

    task automatic wait_done_and_check(input int n);
        int budget = 0;
        while (!done && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("done", done, 1'b1);
        check("core_rst_n_run", core_rst_n, 1'b1);
        check("loaded_words", loaded_words, n);
        check("error_clear", error, 1'b0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_core_rst_n", core_rst_n, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_loaded_words", loaded_words, 0);
        check("rst_state", fsm_state, ST_IDLE);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_hold", fsm_state, ST_IDLE);

        // Basic load of the three reference instructions
        words[0] = 32'h00C0_8093;
        words[1] = 32'h0120_8113;
        words[2] = 32'h0020_E1B3;
        pulse_start(1'b1);
        send_words(3, 1'b1, 1'b1);
        wait_done_and_check(3);

        // Restarts from RUN with random programs and spurious start in CLEAR
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, DEPTH);
            fill_random(n);
            pulse_start(1'b1);
            repeat ($urandom_range(1, 6)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            send_words(n, 1'b1, 1'b1);
            wait_done_and_check(n);
        end

        // Overflow: DEPTH words without s_last
        fill_random(DEPTH);
        pulse_start(1'b1);
        send_words(DEPTH, 1'b0, 1'b1);
        check("ovf_error", error, 1'b1);
        check("ovf_core_rst_n", core_rst_n, 1'b0);
        check("ovf_done", done, 1'b0);
        check("ovf_loaded_words", loaded_words, DEPTH);
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("ovf_s_ready", s_ready, 1'b0);
        check("ovf_state", fsm_state, ST_ERROR);
        s_valid = 1'b0;
        check("ovf_queue", exp_q.size(), 0);
        pulse_start(1'b1);
        n = $urandom_range(1, DEPTH);
        fill_random(n);
        send_words(n, 1'b1, 1'b1);
        wait_done_and_check(n);

        // Reset in the middle of LOAD after two accepted beats
        fill_random(DEPTH);
        pulse_start(1'b1);
        send_words(2, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_queue", exp_q.size(), 0);
        s_valid = 1'b1;
        reset   = 1'b0;
        #1;
        check("mid_s_ready", s_ready, 1'b0);
        check("mid_core_rst_n", core_rst_n, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_imem_we", imem_we, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_state", fsm_state, ST_IDLE);
        check("post_rst_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;

        // Fresh load after the aborted one re-clears the memories
        n = $urandom_range(1, DEPTH);
        fill_random(n);
        pulse_start(1'b1);
        send_words(n, 1'b1, 1'b1);
        wait_done_and_check(n);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
